// File: rtl/markov_predictor.sv
// Rock-paper-scissors opponent: learns a Markov table of (recent move pairs) -> user's next move
// and plays the move that beats the most likely one. Valid/ready round handshake, saturating scores.
module markov_predictor #(
  parameter int          HIST_LEN = 1,
  parameter int          CNT_W    = 8,
  parameter int          SCORE_W  = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               move_valid_i,
  output logic               move_ready_o,
  input  logic [1:0]         user_move_i,
  output logic               choice_valid_o,
  output logic [1:0]         choice_o,
  output logic               illegal_o,
  output logic [SCORE_W-1:0] user_wins_o,
  output logic [SCORE_W-1:0] cpu_wins_o
);

  localparam int         NUM_CTX = (HIST_LEN == 2) ? 81 : 9;
  localparam int         CTX_W   = $clog2(NUM_CTX);
  localparam logic [1:0] FULL    = 2'(HIST_LEN);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE, S_PREDICT} state_e;

  state_e                                 state_q, state_d;
  logic [NUM_CTX-1:0][2:0][CNT_W-1:0]     tbl_q, tbl_d;
  logic [CTX_W-1:0]                       row_q, row_d;
  logic [HIST_LEN-1:0][3:0]               hist_q, hist_d;  // {user, cpu}, [0] newest
  logic [1:0]                             fill_q, fill_d;
  logic [1:0]                             move_q, move_d;
  logic                                   illegal_q, illegal_d;
  logic [1:0]                             choice_q, choice_d;
  logic [SCORE_W-1:0]                     uw_q, uw_d, cw_q, cw_d;
  logic [15:0]                            lfsr_q;

  logic [CTX_W-1:0]                       ctx;
  logic [2:0][CNT_W-1:0]                  cur;
  logic [CNT_W-1:0]                       mx, tgt;
  logic [2:0]                             tie;
  logic [1:0]                             rnd, p, pred_choice;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd0 && b == 2'd1) || (a == 2'd1 && b == 2'd2) || (a == 2'd2 && b == 2'd0);
  endfunction

  // Context index: base-9 digits of (3*user + cpu), newest round least significant
  always_comb begin
    int acc;
    acc = 0;
    for (int k = HIST_LEN - 1; k >= 0; k--)
      acc = acc * 9 + 3 * int'(hist_q[k][3:2]) + int'(hist_q[k][1:0]);
    ctx = CTX_W'(acc);
  end

  always_comb begin
    cur = tbl_q[ctx];
    mx  = cur[0];
    if (cur[1] > mx) mx = cur[1];
    if (cur[2] > mx) mx = cur[2];
    for (int j = 0; j < 3; j++) tie[j] = (cur[j] == mx);
    rnd = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
    case (tie)
      3'b001:  p = 2'd0;
      3'b010:  p = 2'd1;
      3'b100:  p = 2'd2;
      3'b011:  p = lfsr_q[0] ? 2'd1 : 2'd0;
      3'b101:  p = lfsr_q[0] ? 2'd2 : 2'd0;
      3'b110:  p = lfsr_q[0] ? 2'd2 : 2'd1;
      default: p = rnd;
    endcase
    if (fill_q != FULL) p = rnd;
    pred_choice = (p == 2'd0) ? 2'd2 : (p == 2'd1) ? 2'd0 : 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    tbl_d     = tbl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    move_d    = move_q;
    illegal_d = 1'b0;
    choice_d  = choice_q;
    uw_d      = uw_q;
    cw_d      = cw_q;
    tgt       = tbl_q[ctx][move_q];
    case (state_q)
      S_INIT: begin
        tbl_d[row_q] = '0;
        if (row_q == CTX_W'(NUM_CTX - 1)) state_d = S_PREDICT;
        else                              row_d   = row_q + CTX_W'(1);
      end
      S_IDLE: begin
        if (move_valid_i) begin
          move_d    = user_move_i;
          illegal_d = (user_move_i == 2'b11);
          state_d   = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (illegal_q) begin
          state_d = S_IDLE;
        end else begin
          if (beats(move_q, choice_q) && uw_q != '1) uw_d = uw_q + SCORE_W'(1);
          if (beats(choice_q, move_q) && cw_q != '1) cw_d = cw_q + SCORE_W'(1);
          if (fill_q == FULL) begin
            // A saturated counter halves its whole row so relative odds survive
            if (tgt == '1) begin
              for (int j = 0; j < 3; j++) tbl_d[ctx][j] = tbl_q[ctx][j] >> 1;
              tbl_d[ctx][move_q] = (tgt >> 1) + CNT_W'(1);
            end else begin
              tbl_d[ctx][move_q] = tgt + CNT_W'(1);
            end
          end
          for (int k = HIST_LEN - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
          hist_d[0] = {move_q, choice_q};
          if (fill_q != FULL) fill_d = fill_q + 2'd1;
          state_d = S_PREDICT;
        end
      end
      S_PREDICT: begin
        choice_d = pred_choice;
        state_d  = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    if (clear_i) begin
      state_d   = S_INIT;
      row_d     = '0;
      tbl_d     = tbl_q;
      hist_d    = '0;
      fill_d    = '0;
      illegal_d = 1'b0;
      choice_d  = choice_q;
      uw_d      = '0;
      cw_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      row_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      move_q    <= '0;
      illegal_q <= 1'b0;
      choice_q  <= '0;
      uw_q      <= '0;
      cw_q      <= '0;
      lfsr_q    <= SEED;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      move_q    <= move_d;
      illegal_q <= illegal_d;
      choice_q  <= choice_d;
      uw_q      <= uw_d;
      cw_q      <= cw_d;
      lfsr_q    <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  // Table contents are established by INIT after every reset/clear
  always_ff @(posedge clock) tbl_q <= tbl_d;

  assign move_ready_o   = (state_q == S_IDLE);
  assign choice_valid_o = (state_q == S_IDLE);
  assign choice_o       = choice_q;
  assign illegal_o      = illegal_q;
  assign user_wins_o    = uw_q;
  assign cpu_wins_o     = cw_q;

endmodule

// File: tb/tb_markov_predictor.sv
// Directed + random rounds against a per-round reference model of the predictor (HIST_LEN=1,
// 3-bit counters, 2-bit scores so aging and saturation are reached quickly).
module tb_markov_predictor;
  localparam int H = 1, CW = 3, SW = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int CMAX = 7, SMAX = 3;

  logic clock = 1'b0, reset, clear_i, move_valid_i;
  logic [1:0] user_move_i;
  logic move_ready_o, choice_valid_o, illegal_o;
  logic [1:0] choice_o;
  logic [SW-1:0] user_wins_o, cpu_wins_o;

  markov_predictor #(.HIST_LEN(H), .CNT_W(CW), .SCORE_W(SW), .SEED(SEED)) dut (
    .clock(clock), .reset(reset), .clear_i(clear_i), .move_valid_i(move_valid_i),
    .move_ready_o(move_ready_o), .user_move_i(user_move_i), .choice_valid_o(choice_valid_o),
    .choice_o(choice_o), .illegal_o(illegal_o), .user_wins_o(user_wins_o), .cpu_wins_o(cpu_wins_o));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  int T[9][3];
  int m_hu, m_hc, m_fill, m_uw, m_cw, m_choice;
  logic [15:0] m_lfsr, m_lfsr_prev;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  always @(posedge clock or negedge reset)
    if (!reset) begin m_lfsr <= SEED; m_lfsr_prev <= SEED; end
    else begin m_lfsr_prev <= m_lfsr; m_lfsr <= lstep(m_lfsr); end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Most likely user move with the tie rules, then the move that beats it
  function automatic int predict(input int r0, input int r1, input int r2, input bit full,
                                 input logic [15:0] l);
    int row[3];
    int mx, rnd, pm;
    int tied[$];
    row[0] = r0; row[1] = r1; row[2] = r2;
    mx = r0;
    if (r1 > mx) mx = r1;
    if (r2 > mx) mx = r2;
    for (int m = 0; m < 3; m++) if (row[m] == mx) tied.push_back(m);
    rnd = int'(l[1:0]);
    if (rnd == 3) rnd = 0;
    if (!full || tied.size() == 3) pm = rnd;
    else if (tied.size() == 1)     pm = tied[0];
    else                           pm = l[0] ? tied[1] : tied[0];
    return (pm + 2) % 3;
  endfunction

  task automatic model_init();
    for (int r = 0; r < 9; r++) for (int m = 0; m < 3; m++) T[r][m] = 0;
    m_hu = 0; m_hc = 0; m_fill = 0; m_uw = 0; m_cw = 0;
  endtask

  task automatic model_update(input int u);
    int c, ctx;
    c = m_choice;
    if (c == (u + 1) % 3 && m_uw < SMAX) m_uw++;
    if (u == (c + 1) % 3 && m_cw < SMAX) m_cw++;
    if (m_fill == H) begin
      ctx = 3 * m_hu + m_hc;
      if (T[ctx][u] == CMAX) for (int m = 0; m < 3; m++) T[ctx][m] = T[ctx][m] / 2;
      T[ctx][u] = T[ctx][u] + 1;
    end
    m_hu = u; m_hc = c; m_fill = H;
  endtask

  task automatic model_predict();
    int ctx;
    ctx = 3 * m_hu + m_hc;
    m_choice = predict(T[ctx][0], T[ctx][1], T[ctx][2], m_fill == H, m_lfsr_prev);
  endtask

  task automatic check_state();
    logic [8:0][2:0][CW-1:0] e;
    for (int r = 0; r < 9; r++) for (int m = 0; m < 3; m++) e[r][m] = CW'(T[r][m]);
    chk("choice", choice_o, m_choice);
    chk("choice_valid", choice_valid_o, 1'b1);
    chk("user_wins", user_wins_o, m_uw);
    chk("cpu_wins", cpu_wins_o, m_cw);
    chk("table", dut.tbl_q, e);
  endtask

  // Called on the first negedge of INIT; counts negedges until IDLE
  task automatic wait_init();
    int n;
    n = 0;
    while (!move_ready_o && n < 30) begin n++; @(negedge clock); end
    chk("init_len", n, 10);
    model_predict();
    check_state();
  endtask

  task automatic play(input int u, input bit hold);
    int n;
    move_valid_i = 1'b1; user_move_i = 2'(u);
    @(negedge clock);
    if (!hold) move_valid_i = 1'b0;
    else user_move_i = 2'($urandom_range(0, 2));
    chk("illegal_pulse", illegal_o, (u == 3));
    chk("ready_drop", move_ready_o, 1'b0);
    if (u != 3) model_update(u);
    n = 0;
    while (!move_ready_o && n < 20) begin @(negedge clock); n++; move_valid_i = 1'b0; end
    chk("latency", n, (u == 3) ? 1 : 2);
    chk("illegal_low", illegal_o, 1'b0);
    if (u != 3) model_predict();
    check_state();
    if (hold) begin
      repeat (2) @(negedge clock);
      chk("no_queue", move_ready_o, 1'b1);
      check_state();
    end
  endtask

  task automatic do_clear(input bit with_hs);
    clear_i = 1'b1;
    if (with_hs) begin move_valid_i = 1'b1; user_move_i = 2'd1; end
    @(negedge clock);
    clear_i = 1'b0; move_valid_i = 1'b0;
    chk("clr_ready", move_ready_o, 1'b0);
    chk("clr_uw", user_wins_o, 0);
    chk("clr_cw", cpu_wins_o, 0);
    chk("clr_illegal", illegal_o, 1'b0);
    model_init();
    wait_init();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, move_ready_o, 1'b0);
    chk({tag, "_cvalid"}, choice_valid_o, 1'b0);
    chk({tag, "_choice"}, choice_o, 2'd0);
    chk({tag, "_illegal"}, illegal_o, 1'b0);
    chk({tag, "_uw"}, user_wins_o, 0);
    chk({tag, "_cw"}, cpu_wins_o, 0);
  endtask

  initial begin
    reset = 1'b0; clear_i = 1'b0; move_valid_i = 1'b0; user_move_i = 2'd0;
    m_choice = 0; model_init();
    repeat (3) @(negedge clock);
    check_reset_outs("reset");
    reset = 1'b1;
    wait_init();

    // Constant rock: cpu locks onto paper, counters age in the (rock,paper) row
    for (int i = 0; i < 30; i++) play(0, 1'b0);
    chk("rock_locked", choice_o, 2'd2);

    // Illegal move leaves everything but the pulse untouched
    play(3, 1'b0);
    // move_valid held into UPDATE is not queued
    play(1, 1'b1);

    // clear together with a handshake, then clear during UPDATE
    do_clear(1'b1);
    move_valid_i = 1'b1; user_move_i = 2'((m_choice + 2) % 3);
    @(negedge clock);
    move_valid_i = 1'b0; clear_i = 1'b1;
    @(negedge clock);
    clear_i = 1'b0;
    chk("clr_upd_uw", user_wins_o, 0);
    chk("clr_upd_cw", cpu_wins_o, 0);
    chk("clr_upd_ready", move_ready_o, 1'b0);
    model_init();
    wait_init();

    // User wins five in a row: score saturates
    for (int i = 0; i < 5; i++) play((m_choice + 2) % 3, 1'b0);
    chk("uw_sat", user_wins_o, 2'd3);

    // Async reset while in PREDICT
    move_valid_i = 1'b1; user_move_i = 2'd0;
    @(negedge clock);
    move_valid_i = 1'b0;
    @(negedge clock);
    chk("in_predict", move_ready_o, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_outs("midreset");
    m_choice = 0; model_init();
    @(negedge clock);
    reset = 1'b1;
    wait_init();

    // Random rounds with occasional clears
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 11) == 0) do_clear(1'b0);
      else play(int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
